// File: rtl/axi_stream_line_arbiter_pkg.sv
// Shared types and constants for the AXI-Stream line arbiter.
package axi_stream_line_arbiter_pkg;

  localparam int FDATA               = 32;
  localparam int ARB_NUM_REQ_DEF     = 4;
  localparam int ARB_LINE_PIXELS_DEF = 640;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

  // Width of a source index; never below one bit.
  function automatic int arb_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_stream_line_arbiter_if.sv
// Bundle of source-side and stream-side signals around the line arbiter.
// slave  : the arbiter's view.
// master : the environment's view (sources + stream master).
interface axi_stream_line_arbiter_if
  import axi_stream_line_arbiter_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ_DEF
) ();

  localparam int ID_W = arb_id_width(NUM_REQ);

  logic                            arb_en;
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0][FDATA-1:0]   req_data;
  logic [NUM_REQ-1:0]              req_ready;
  logic                            rgb_valid;
  logic [FDATA-1:0]                rgb_in;
  logic                            datapath_ready;
  logic                            grant_valid;
  logic [ID_W-1:0]                 grant_id;
  logic                            line_done;

  modport slave (
    input  arb_en, req_valid, req_data, datapath_ready,
    output req_ready, rgb_valid, rgb_in, grant_valid, grant_id, line_done
  );

  modport master (
    output arb_en, req_valid, req_data, datapath_ready,
    input  req_ready, rgb_valid, rgb_in, grant_valid, grant_id, line_done
  );

endinterface

// File: rtl/stream_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above
// rr_ptr, wrapping around. Feeding rr_ptr=0 turns it into fixed priority.
module stream_rr_picker
  import axi_stream_line_arbiter_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ_DEF,
  parameter int ID_W    = arb_id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    win_id,
  output logic               win_valid
);

  // Scan NUM_REQ positions starting at rr_ptr; keep the first hit.
  always_comb begin
    logic [ID_W-1:0] idx;
    win_valid = 1'b0;
    win_id    = ID_W'(0);
    idx       = ID_W'(0);
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win_id    = idx;
      end else begin
        // earlier winner (or none yet) stands
      end
    end
  end

endmodule

// File: rtl/axi_stream_line_arbiter.sv
// Line-granular arbiter sharing one AXI-Stream datapath among NUM_REQ
// pixel sources. A grant lasts exactly LINE_PIXELS accepted beats, then a
// one-cycle IDLE slot re-arbitrates.
// Build option: STREAM_ARB_FIXED_PRIO_EN -- lowest index wins, no rotating
// pointer. Default build: round-robin pointer advanced on each line end.
module axi_stream_line_arbiter
  import axi_stream_line_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = ARB_NUM_REQ_DEF,
  parameter int LINE_PIXELS = ARB_LINE_PIXELS_DEF,
  parameter int CNT_W       = $clog2(LINE_PIXELS + 1)
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  axi_stream_line_arbiter_if.slave    bus
);

  localparam int              ID_W      = arb_id_width(NUM_REQ);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_PIXELS - 1);

  arb_state_t         state_r, state_nxt;
  logic [ID_W-1:0]    grant_id_r, grant_id_nxt;
  logic [CNT_W-1:0]   beat_cnt_r, beat_cnt_nxt;
  logic               line_done_r, line_done_nxt;

  logic [ID_W-1:0]    rr_ptr_s;
  logic [ID_W-1:0]    win_id_s;
  logic               win_valid_s;
  logic               beat_acc_s;
  logic               line_end_s;

  logic               rgb_valid_s;
  logic [FDATA-1:0]   rgb_in_s;
  logic [NUM_REQ-1:0] req_ready_s;

  // A beat moves when the granted source offers and the datapath takes it.
  assign beat_acc_s = (state_r == ARB_XFER) && bus.req_valid[grant_id_r] && bus.datapath_ready;
  assign line_end_s = beat_acc_s && (beat_cnt_r == LAST_BEAT);

`ifdef STREAM_ARB_FIXED_PRIO_EN
  assign rr_ptr_s = ID_W'(0);
`else
  logic [ID_W-1:0] rr_ptr_r, rr_ptr_nxt;

  assign rr_ptr_s = rr_ptr_r;

  // Pointer moves to the source after the one that just finished a line.
  always_comb begin
    rr_ptr_nxt = rr_ptr_r;
    if (line_end_s) begin
      if (grant_id_r == ID_W'(NUM_REQ - 1)) begin
        rr_ptr_nxt = ID_W'(0);
      end else begin
        rr_ptr_nxt = grant_id_r + ID_W'(1);
      end
    end else begin
      rr_ptr_nxt = rr_ptr_r;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rr_ptr_r <= ID_W'(0);
    end else begin
      rr_ptr_r <= rr_ptr_nxt;
    end
  end
`endif

  stream_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req       (bus.req_valid),
    .rr_ptr    (rr_ptr_s),
    .win_id    (win_id_s),
    .win_valid (win_valid_s)
  );

  // FSM next state, grant latch, beat counting and line-end pulse.
  always_comb begin
    state_nxt     = state_r;
    grant_id_nxt  = grant_id_r;
    beat_cnt_nxt  = beat_cnt_r;
    line_done_nxt = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (bus.arb_en && win_valid_s) begin
          state_nxt    = ARB_XFER;
          grant_id_nxt = win_id_s;
          beat_cnt_nxt = CNT_W'(0);
        end else begin
          state_nxt    = ARB_IDLE;
        end
      end
      ARB_XFER: begin
        if (line_end_s) begin
          state_nxt     = ARB_IDLE;
          beat_cnt_nxt  = CNT_W'(0);
          line_done_nxt = 1'b1;
        end else if (beat_acc_s) begin
          beat_cnt_nxt  = beat_cnt_r + CNT_W'(1);
        end else begin
          beat_cnt_nxt  = beat_cnt_r;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  // State, grant and counter registers; reset abandons any partial line.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r     <= ARB_IDLE;
      grant_id_r  <= ID_W'(0);
      beat_cnt_r  <= CNT_W'(0);
      line_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      grant_id_r  <= grant_id_nxt;
      beat_cnt_r  <= beat_cnt_nxt;
      line_done_r <= line_done_nxt;
    end
  end

  // Pass the granted source straight through; everything else stays quiet.
  always_comb begin
    rgb_valid_s = 1'b0;
    rgb_in_s    = FDATA'(0);
    req_ready_s = NUM_REQ'(0);
    if (state_r == ARB_XFER) begin
      rgb_valid_s             = bus.req_valid[grant_id_r];
      rgb_in_s                = bus.req_data[grant_id_r];
      req_ready_s[grant_id_r] = bus.datapath_ready;
    end else begin
      rgb_valid_s = 1'b0;
    end
  end

  assign bus.rgb_valid   = rgb_valid_s;
  assign bus.rgb_in      = rgb_in_s;
  assign bus.req_ready   = req_ready_s;
  assign bus.grant_valid = (state_r == ARB_XFER);
  assign bus.grant_id    = grant_id_r;
  assign bus.line_done   = line_done_r;

endmodule

// File: tb/tb_axi_stream_line_arbiter.sv
// Directed bench for axi_stream_line_arbiter (NUM_REQ=4, LINE_PIXELS=8).
// Each source emits {8'(index), 24-bit beat counter}; the counter advances
// only on a source-side handshake, so lost or duplicated beats show up as
// data that breaks the expected sequence.
module tb_axi_stream_line_arbiter;
  import axi_stream_line_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int LP   = 8;

  logic        aclk;
  logic        aresetn;
  logic        src_clr;
  logic [23:0] src_cnt [NREQ];
  int          exp_cnt [NREQ];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          beats    = 0;

  typedef struct {
    int         cyc;
    logic       en;
    logic [3:0] rv;
    logic       dr;
    logic       gv;
    logic [1:0] gid;
    logic       rgbv;
    logic [3:0] rdy;
    logic       ld;
  } vec_t;

  vec_t vecs [12];

  axi_stream_line_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  axi_stream_line_arbiter #(
    .NUM_REQ     (NREQ),
    .LINE_PIXELS (LP)
  ) dut (
    .ACLK    (aclk),
    .ARESETn (aresetn),
    .bus     (bus)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_src
    assign bus.req_data[gi] = {8'(gi), src_cnt[gi]};
    always_ff @(posedge aclk) begin
      if (src_clr) src_cnt[gi] <= 24'd0;
      else if (bus.req_valid[gi] && bus.req_ready[gi]) src_cnt[gi] <= src_cnt[gi] + 24'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #3;
  endtask

  task automatic check_beat(input logic [1:0] id);
    if (bus.rgb_valid && bus.datapath_ready) begin
      chk("rgb_in", bus.rgb_in, {6'd0, id, 24'(exp_cnt[id])});
      exp_cnt[id]++;
      beats++;
    end
  endtask

  task automatic do_reset();
    aresetn            = 1'b0;
    bus.req_valid      = 4'b0000;
    bus.arb_en         = 1'b0;
    bus.datapath_ready = 1'b0;
    src_clr            = 1'b1;
    repeat (2) @(posedge aclk);
    #3;
    aresetn = 1'b1;
    src_clr = 1'b0;
    beats   = 0;
    for (int i = 0; i < NREQ; i++) exp_cnt[i] = 0;
  endtask

  task automatic run_beats(input int n, input logic [1:0] id);
    for (int i = 0; i < n; i++) begin
      step();
      #1;
      chk("xfer grant_valid", 32'(bus.grant_valid), 32'd1);
      chk("xfer grant_id", 32'(bus.grant_id), 32'(id));
      chk("xfer req_ready", 32'(bus.req_ready), 32'(4'b0001 << id));
      chk("xfer rgb_valid", 32'(bus.rgb_valid), 32'd1);
      check_beat(id);
    end
  endtask

  task automatic idle_done();
    step();
    #1;
    chk("line_done pulse", 32'(bus.line_done), 32'd1);
    chk("idle grant_valid", 32'(bus.grant_valid), 32'd0);
    chk("idle rgb_valid", 32'(bus.rgb_valid), 32'd0);
    chk("idle rgb_in", bus.rgb_in, 32'd0);
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, " grant_valid"}, 32'(bus.grant_valid), 32'd0);
    chk({tag, " grant_id"}, 32'(bus.grant_id), 32'd0);
    chk({tag, " rgb_valid"}, 32'(bus.rgb_valid), 32'd0);
    chk({tag, " req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, " rgb_in"}, bus.rgb_in, 32'd0);
    chk({tag, " line_done"}, 32'(bus.line_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [1:0] gid_e;

    // idle with no requests, then one line from source 0 with a 1010 ready pattern
    vecs[0]  = '{20, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};
    vecs[1]  = '{1,  1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};
    vecs[2]  = '{1,  1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b0};
    vecs[3]  = '{1,  1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0};
    vecs[4]  = '{1,  1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b0};
    vecs[5]  = '{1,  1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0};
    vecs[6]  = '{1,  1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b0};
    vecs[7]  = '{1,  1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0};
    vecs[8]  = '{1,  1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b0};
    vecs[9]  = '{4,  1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b0};
    vecs[10] = '{1,  1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1};
    vecs[11] = '{2,  1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};

    // Reset state, checked while reset is held
    aresetn            = 1'b0;
    src_clr            = 1'b1;
    bus.arb_en         = 1'b0;
    bus.req_valid      = 4'b0000;
    bus.datapath_ready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    reset_outputs_zero("in reset");
    do_reset();

    // Table: idle period and datapath_ready toggling mid-line
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < vecs[r].cyc; c++) begin
        step();
        bus.arb_en         = vecs[r].en;
        bus.req_valid      = vecs[r].rv;
        bus.datapath_ready = vecs[r].dr;
        #1;
        chk($sformatf("vec%0d grant_valid", r), 32'(bus.grant_valid), 32'(vecs[r].gv));
        chk($sformatf("vec%0d grant_id", r), 32'(bus.grant_id), 32'(vecs[r].gid));
        chk($sformatf("vec%0d rgb_valid", r), 32'(bus.rgb_valid), 32'(vecs[r].rgbv));
        chk($sformatf("vec%0d req_ready", r), 32'(bus.req_ready), 32'(vecs[r].rdy));
        chk($sformatf("vec%0d line_done", r), 32'(bus.line_done), 32'(vecs[r].ld));
        if (vecs[r].gv) check_beat(vecs[r].gid);
        else chk($sformatf("vec%0d rgb_in idle", r), bus.rgb_in, 32'd0);
      end
    end
    chk("toggle beat count", 32'(beats), 32'd8);

    // All four sources requesting: five lines, 9-cycle cadence
    do_reset();
    step();
    bus.req_valid      = 4'b1111;
    bus.arb_en         = 1'b1;
    bus.datapath_ready = 1'b1;
    #1;
    chk("rr first idle grant_valid", 32'(bus.grant_valid), 32'd0);
    for (int l = 0; l < 5; l++) begin
`ifdef STREAM_ARB_FIXED_PRIO_EN
      gid_e = 2'd0;
`else
      gid_e = 2'(l % 4);
`endif
      run_beats(LP, gid_e);
      idle_done();
    end
    chk("rr total beats", 32'(beats), 32'd40);

    // Source 1 alone, request dropped for 3 cycles after beat 4
    do_reset();
    step();
    bus.req_valid      = 4'b0010;
    bus.arb_en         = 1'b1;
    bus.datapath_ready = 1'b1;
    #1;
    chk("gap idle grant_valid", 32'(bus.grant_valid), 32'd0);
    run_beats(4, 2'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      bus.req_valid = 4'b0000;
      #1;
      chk("gap grant_valid", 32'(bus.grant_valid), 32'd1);
      chk("gap grant_id", 32'(bus.grant_id), 32'd1);
      chk("gap rgb_valid", 32'(bus.rgb_valid), 32'd0);
      chk("gap req_ready", 32'(bus.req_ready), 32'(4'b0010));
    end
    step();
    bus.req_valid = 4'b0010;
    #1;
    chk("gap resume rgb_valid", 32'(bus.rgb_valid), 32'd1);
    check_beat(2'd1);
    run_beats(3, 2'd1);
    idle_done();
    chk("gap beat count", 32'(beats), 32'd8);

    // arb_en dropped at beat 2 of source 2
    do_reset();
    step();
    bus.req_valid      = 4'b0100;
    bus.arb_en         = 1'b1;
    bus.datapath_ready = 1'b1;
    #1;
    run_beats(2, 2'd2);
    step();
    bus.arb_en = 1'b0;
    #1;
    chk("en-off grant_valid", 32'(bus.grant_valid), 32'd1);
    check_beat(2'd2);
    run_beats(5, 2'd2);
    idle_done();
    for (int c = 0; c < 5; c++) begin
      step();
      #1;
      chk("en-off hold grant_valid", 32'(bus.grant_valid), 32'd0);
    end
    step();
    bus.arb_en = 1'b1;
    #1;
    chk("en-on bubble grant_valid", 32'(bus.grant_valid), 32'd0);
    run_beats(5, 2'd2);

    // Reset at beat 5 of source 2; pointer must return to 0
    step();
    aresetn = 1'b0;
    #1;
    reset_outputs_zero("mid-line reset");
    do_reset();
    step();
    bus.req_valid      = 4'b1100;
    bus.arb_en         = 1'b1;
    bus.datapath_ready = 1'b1;
    #1;
    chk("post-reset line_done", 32'(bus.line_done), 32'd0);
    chk("post-reset grant_valid", 32'(bus.grant_valid), 32'd0);
    step();
    #1;
    chk("post-reset 1100 grant_valid", 32'(bus.grant_valid), 32'd1);
    chk("post-reset 1100 grant_id", 32'(bus.grant_id), 32'd2);
    step();
    aresetn = 1'b0;
    #1;
    do_reset();
    step();
    bus.req_valid      = 4'b0110;
    bus.arb_en         = 1'b1;
    bus.datapath_ready = 1'b1;
    #1;
    chk("post-reset 0110 idle", 32'(bus.grant_valid), 32'd0);
    step();
    #1;
    chk("post-reset 0110 grant_valid", 32'(bus.grant_valid), 32'd1);
    chk("post-reset 0110 grant_id", 32'(bus.grant_id), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
